// File: rtl/collision_pkg.sv
// Shared types and sizing helpers for the frog/obstacle collision scanner.
package collision_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int TILE_SIZE_DEF = 32;
    localparam int X_W_DEF       = 10;
    localparam int Y_W_DEF       = 10;

    // Slot index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Hit-count width, wide enough to hold n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Request/result bundle between the game logic and collision_scanner.
interface collision_scanner_if #(
    parameter int NB_OBJ = 8,
    parameter int X_W    = 10,
    parameter int Y_W    = 10
);
    import collision_pkg::*;

    localparam int IW = idx_w(NB_OBJ);
    localparam int CW = cnt_w(NB_OBJ);

    logic                  i_Start;
    logic [X_W-1:0]        i_Frog_X;
    logic [Y_W-1:0]        i_Frog_Y;
    logic [NB_OBJ*X_W-1:0] i_Obj_X;
    logic [NB_OBJ*Y_W-1:0] i_Obj_Y;
    logic [NB_OBJ-1:0]     i_Obj_Valid;
    logic                  o_Busy;
    logic                  o_Done;
    logic                  o_Has_Collided;
    logic [IW-1:0]         o_Hit_Idx;
    logic [CW-1:0]         o_Hit_Count;

    modport master (
        output i_Start, i_Frog_X, i_Frog_Y, i_Obj_X, i_Obj_Y, i_Obj_Valid,
        input  o_Busy, o_Done, o_Has_Collided, o_Hit_Idx, o_Hit_Count
    );

    modport slave (
        input  i_Start, i_Frog_X, i_Frog_Y, i_Obj_X, i_Obj_Y, i_Obj_Valid,
        output o_Busy, o_Done, o_Has_Collided, o_Hit_Idx, o_Hit_Count
    );

endinterface

// File: rtl/collision_scanner_aabb_overlap.sv
// Combinational strict AABB overlap of two equal square boxes, each shrunk by margin per side.
module aabb_overlap #(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int C_W = 11
) (
    input  logic [X_W-1:0] f_x,
    input  logic [Y_W-1:0] f_y,
    input  logic [X_W-1:0] o_x,
    input  logic [Y_W-1:0] o_y,
    input  logic [C_W-1:0] size,
    input  logic [C_W-1:0] margin,
    output logic           overlap
);

    logic [C_W-1:0] fx, fy, ox, oy;

    // One extra bit of headroom keeps coord+size from wrapping at the screen edge.
    assign fx = C_W'(f_x);
    assign fy = C_W'(f_y);
    assign ox = C_W'(o_x);
    assign oy = C_W'(o_y);

    assign overlap = (fx + margin < ox + size - margin) &&
                     (ox + margin < fx + size - margin) &&
                     (fy + margin < oy + size - margin) &&
                     (oy + margin < fy + size - margin);

endmodule

// File: rtl/collision_scanner.sv
// Frame-triggered obstacle scanner: one slot per cycle through a single AABB comparator.
// Define COLLISION_HITBOX_SHRINK_EN to shrink both boxes by HITBOX_MARGIN on every side.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int TILE_SIZE     = TILE_SIZE_DEF,
    parameter int NB_OBJ        = 8,
    parameter int X_W           = X_W_DEF,
    parameter int Y_W           = Y_W_DEF,
    parameter int HITBOX_MARGIN = 4
) (
    input logic               i_Clk,
    input logic               i_Rst_L,
    collision_scanner_if.slave bus
);

    localparam int IW  = idx_w(NB_OBJ);
    localparam int CW  = cnt_w(NB_OBJ);
    localparam int C_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
`ifdef COLLISION_HITBOX_SHRINK_EN
    localparam int MARGIN = HITBOX_MARGIN;
`else
    // Full-box build: the margin exists as a parameter but has no effect.
    localparam int MARGIN = 0 * HITBOX_MARGIN;
`endif
    localparam logic [IW-1:0] LAST = IW'(NB_OBJ - 1);

    state_t                state;
    logic [IW-1:0]         idx;
    logic [X_W-1:0]        snap_fx;
    logic [Y_W-1:0]        snap_fy;
    logic [NB_OBJ*X_W-1:0] snap_ox;
    logic [NB_OBJ*Y_W-1:0] snap_oy;
    logic [NB_OBJ-1:0]     snap_v;
    logic                  acc_hit;
    logic [IW-1:0]         acc_idx;
    logic [CW-1:0]         acc_cnt;
    logic                  overlap;
    logic                  slot_hit;

    aabb_overlap #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) u_cmp (
        .f_x     (snap_fx),
        .f_y     (snap_fy),
        .o_x     (snap_ox[idx*X_W +: X_W]),
        .o_y     (snap_oy[idx*Y_W +: Y_W]),
        .size    (C_W'(TILE_SIZE)),
        .margin  (C_W'(MARGIN)),
        .overlap (overlap)
    );

    assign slot_hit = overlap && snap_v[idx];

    // Snapshot is pure data; it is only meaningful once a scan is accepted.
    always_ff @(posedge i_Clk) begin
        if (state == IDLE && bus.i_Start) begin
            snap_fx <= bus.i_Frog_X;
            snap_fy <= bus.i_Frog_Y;
            snap_ox <= bus.i_Obj_X;
            snap_oy <= bus.i_Obj_Y;
            snap_v  <= bus.i_Obj_Valid;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state              <= IDLE;
            idx                <= '0;
            acc_hit            <= 1'b0;
            acc_idx            <= '0;
            acc_cnt            <= '0;
            bus.o_Busy         <= 1'b0;
            bus.o_Done         <= 1'b0;
            bus.o_Has_Collided <= 1'b0;
            bus.o_Hit_Idx      <= '0;
            bus.o_Hit_Count    <= '0;
        end else begin
            bus.o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_Start) begin
                        state      <= SCAN;
                        bus.o_Busy <= 1'b1;
                        idx        <= '0;
                        acc_hit    <= 1'b0;
                        acc_idx    <= '0;
                        acc_cnt    <= '0;
                    end
                end
                SCAN: begin
                    // Ascending scan order makes the first recorded hit the lowest index.
                    if (slot_hit) begin
                        acc_cnt <= acc_cnt + CW'(1);
                        if (!acc_hit) begin
                            acc_hit <= 1'b1;
                            acc_idx <= idx;
                        end
                    end
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    bus.o_Has_Collided <= acc_hit;
                    bus.o_Hit_Idx      <= acc_idx;
                    bus.o_Hit_Count    <= acc_cnt;
                    bus.o_Done         <= 1'b1;
                    bus.o_Busy         <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
